// File: rtl/tx_word_sequencer.sv
// tx_word_sequencer
//
// Upstream feeder for the byte-serial UART transmit wrapper. 16-bit words
// from the acquisition logic are buffered in a small FIFO. Each word is then
// presented on Data, and its high byte and low byte are requested in turn.
//
// Optional feature macro: TXSEQ_SYNC_EN
//   defined   -> a frame counter is built in. SYNC_WORD is sent ahead of every
//                FRAME_LEN data words, so the host can realign the byte stream.
//   undefined -> only FIFO words are sent. FRAME_LEN and SYNC_WORD are unused.
//
// Ports
//   Clock, Reset        single rising-edge clock, synchronous active-high reset
//   WordIn, WordWrite   enqueue side; a write while full is dropped
//   WordReady           FIFO not full (combinational)
//   Overflow            sticky dropped-write flag, cleared only by Reset
//   Level               FIFO occupancy
//   Data                word under transmission (registered)
//   RequestToSend[1:0]  bit 1 requests Data[15:8], bit 0 requests Data[7:0]
//   DataReceived[1:0]   one-cycle acks, same bit positions as RequestToSend
//   Busy                state not IDLE, or FIFO non-empty
//
// Handshake: RequestToSend is a level request that only changes in the cycle
// after the matching DataReceived bit pulses high. An ack bit that does not
// match the current state is ignored. Data is held constant whenever
// RequestToSend is nonzero.

module tx_word_sequencer #(
  parameter int          DEPTH     = 16,
  parameter int          ADDR_W    = 4,
  parameter int          FRAME_LEN = 8,
  parameter logic [15:0] SYNC_WORD = 16'hA55A
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [15:0]     WordIn,
  input  logic            WordWrite,
  output logic            WordReady,
  output logic            Overflow,
  output logic [ADDR_W:0] Level,
  output logic [15:0]     Data,
  output logic [1:0]      RequestToSend,
  input  logic [1:0]      DataReceived,
  output logic            Busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND_HI = 2'd1,
    ST_SEND_LO = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [15:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       data_q, data_d;
  logic [1:0]        rts_q, rts_d;

  logic full;
  logic push;
  logic pop;

`ifdef TXSEQ_SYNC_EN
  localparam int FC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  // sync_sent: the sync word for the current frame has already been sent.
  // cur_sync: the word in flight is the sync word, so it does not count
  // towards the frame.
  logic            sync_sent_q, sync_sent_d;
  logic            cur_sync_q, cur_sync_d;
`else
  logic [15:0] unused_cfg;
  assign unused_cfg = SYNC_WORD ^ 16'(FRAME_LEN);
`endif

  // Fullness is judged on the registered count. A write that arrives while
  // the FIFO is full is dropped, even if the FSM pops in the same cycle.
  assign full = (count_q == (ADDR_W+1)'(DEPTH));
  assign push = WordWrite && !full;

  // --------------------------------------------------------------------------
  // FSM next-state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rts_d   = rts_q;
    pop     = 1'b0;
`ifdef TXSEQ_SYNC_EN
    frame_cnt_d = frame_cnt_q;
    sync_sent_d = sync_sent_q;
    cur_sync_d  = cur_sync_q;
`endif

    case (state_q)
      ST_IDLE: begin
        rts_d = 2'b00;
        // A sync word is only emitted when data is pending, so the link stays
        // quiet when there is nothing to send.
        if (count_q != '0) begin
`ifdef TXSEQ_SYNC_EN
          if (frame_cnt_q == '0 && !sync_sent_q) begin
            data_d      = SYNC_WORD;
            sync_sent_d = 1'b1;
            cur_sync_d  = 1'b1;
          end else begin
            pop        = 1'b1;
            data_d     = mem_q[rd_ptr_q];
            cur_sync_d = 1'b0;
          end
`else
          pop    = 1'b1;
          data_d = mem_q[rd_ptr_q];
`endif
          rts_d   = 2'b10;
          state_d = ST_SEND_HI;
        end
      end

      ST_SEND_HI: begin
        if (DataReceived[1]) begin
          rts_d   = 2'b01;
          state_d = ST_SEND_LO;
        end
      end

      ST_SEND_LO: begin
        if (DataReceived[0]) begin
          rts_d   = 2'b00;
          state_d = ST_IDLE;
`ifdef TXSEQ_SYNC_EN
          if (!cur_sync_q) begin
            frame_cnt_d = (frame_cnt_q == FC_W'(FRAME_LEN - 1)) ? '0
                                                                : frame_cnt_q + FC_W'(1);
            // Re-arm the sync. It only fires again once the counter is back at 0.
            sync_sent_d = 1'b0;
          end
`endif
        end
      end

      default: begin
        rts_d   = 2'b00;
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO pointer / count / overflow next-state
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    overflow_d = overflow_q | (WordWrite & full);
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // The storage array has no reset. A slot is only read after it has been written.
  always_ff @(posedge Clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= WordIn;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      data_q     <= '0;
      rts_q      <= 2'b00;
`ifdef TXSEQ_SYNC_EN
      frame_cnt_q <= '0;
      sync_sent_q <= 1'b0;
      cur_sync_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      data_q     <= data_d;
      rts_q      <= rts_d;
`ifdef TXSEQ_SYNC_EN
      frame_cnt_q <= frame_cnt_d;
      sync_sent_q <= sync_sent_d;
      cur_sync_q  <= cur_sync_d;
`endif
    end
  end

  assign WordReady     = !full;
  assign Overflow      = overflow_q;
  assign Level         = count_q;
  assign Data          = data_q;
  assign RequestToSend = rts_q;
  assign Busy          = (state_q != ST_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_tx_word_sequencer.sv
// Self-checking bench for tx_word_sequencer.
// The reference model is a word queue plus a transmit phase.
// An independent byte scoreboard (exp_q) is filled when each write is
// accepted, and is drained as the downstream side acknowledges each byte.

module tb_tx_word_sequencer;

  localparam int          DEPTH     = 16;
  localparam int          ADDR_W    = 4;
  localparam int          FRAME_LEN = 2;
  localparam logic [15:0] SYNC_WORD = 16'hA55A;

  // ---------------------------------------------------------------- clock/reset
  logic            Clock = 1'b0;
  logic            Reset;
  logic [15:0]     WordIn;
  logic            WordWrite;
  logic            WordReady;
  logic            Overflow;
  logic [ADDR_W:0] Level;
  logic [15:0]     Data;
  logic [1:0]      RequestToSend;
  logic [1:0]      DataReceived;
  logic            Busy;

  always #5 Clock = ~Clock;

  tx_word_sequencer #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .FRAME_LEN(FRAME_LEN),
    .SYNC_WORD(SYNC_WORD)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .WordIn       (WordIn),
    .WordWrite    (WordWrite),
    .WordReady    (WordReady),
    .Overflow     (Overflow),
    .Level        (Level),
    .Data         (Data),
    .RequestToSend(RequestToSend),
    .DataReceived (DataReceived),
    .Busy         (Busy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- model
  logic [15:0] mdl_fifo[$];
  int          mdl_phase;     // 0 idle, 1 high byte requested, 2 low byte requested
  logic [15:0] mdl_data;
  logic [1:0]  mdl_rts;
  logic        mdl_ovf;
`ifdef TXSEQ_SYNC_EN
  int          mdl_fcnt;
  bit          mdl_sync_sent;
  bit          mdl_cur_sync;
`endif

  // ---------------------------------------------------------------- scoreboard
  logic [7:0] exp_q[$];
  int         n_accepted;
  int         n_checks;
  int         n_pass;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic sb_byte(input string tag, input logic [7:0] obs);
    check_eq({tag, "_avail"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) check_eq(tag, 32'(obs), 32'(exp_q.pop_front()));
  endtask

  task automatic model_reset();
    mdl_fifo.delete();
    exp_q.delete();
    n_accepted = 0;
    mdl_phase  = 0;
    mdl_data   = 16'h0000;
    mdl_rts    = 2'b00;
    mdl_ovf    = 1'b0;
`ifdef TXSEQ_SYNC_EN
    mdl_fcnt      = 0;
    mdl_sync_sent = 1'b0;
    mdl_cur_sync  = 1'b0;
`endif
  endtask

  // Advance the model by one rising edge, using the inputs that were present
  // at that edge. data_pre is the Data value the downstream side latched.
  task automatic model_edge(input logic [15:0] data_pre);
    bit was_full;
    if (Reset) begin
      model_reset();
      return;
    end
    was_full = (mdl_fifo.size() >= DEPTH);
    case (mdl_phase)
      0: begin
        if (mdl_fifo.size() != 0) begin
`ifdef TXSEQ_SYNC_EN
          if (mdl_fcnt == 0 && !mdl_sync_sent) begin
            mdl_data      = SYNC_WORD;
            mdl_sync_sent = 1'b1;
            mdl_cur_sync  = 1'b1;
          end else begin
            mdl_data     = mdl_fifo.pop_front();
            mdl_cur_sync = 1'b0;
          end
`else
          mdl_data = mdl_fifo.pop_front();
`endif
          mdl_rts   = 2'b10;
          mdl_phase = 1;
        end
      end
      1: begin
        if (DataReceived[1]) begin
          sb_byte("byte_hi", data_pre[15:8]);
          mdl_rts   = 2'b01;
          mdl_phase = 2;
        end
      end
      default: begin
        if (DataReceived[0]) begin
          sb_byte("byte_lo", data_pre[7:0]);
          mdl_rts   = 2'b00;
          mdl_phase = 0;
`ifdef TXSEQ_SYNC_EN
          if (!mdl_cur_sync) begin
            mdl_fcnt      = (mdl_fcnt == FRAME_LEN - 1) ? 0 : mdl_fcnt + 1;
            mdl_sync_sent = 1'b0;
          end
`endif
        end
      end
    endcase
    if (WordWrite) begin
      if (was_full) begin
        mdl_ovf = 1'b1;
      end else begin
        mdl_fifo.push_back(WordIn);
`ifdef TXSEQ_SYNC_EN
        if (n_accepted % FRAME_LEN == 0) begin
          exp_q.push_back(SYNC_WORD[15:8]);
          exp_q.push_back(SYNC_WORD[7:0]);
        end
`endif
        exp_q.push_back(WordIn[15:8]);
        exp_q.push_back(WordIn[7:0]);
        n_accepted++;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("level",      32'(Level),         32'(mdl_fifo.size()));
    check_eq("rts",        32'(RequestToSend), 32'(mdl_rts));
    check_eq("data",       32'(Data),          32'(mdl_data));
    check_eq("overflow",   32'(Overflow),      32'(mdl_ovf));
    check_eq("word_ready", 32'(WordReady),     32'(mdl_fifo.size() < DEPTH));
    check_eq("busy",       32'(Busy),          32'(mdl_phase != 0 || mdl_fifo.size() != 0));
  endtask

  // ---------------------------------------------------------------- drivers
  // One clock: the model follows the edge, and the outputs are checked 1 time unit later.
  task automatic step();
    logic [15:0] data_pre;
    data_pre = Data;
    @(posedge Clock);
    model_edge(data_pre);
    #1;
    check_outputs();
  endtask

  function automatic logic [1:0] rand_ack(input logic [1:0] rts, input int p_match);
    int r;
    r = int'($urandom_range(0, 99));
    if (rts == 2'b00) return (r < 10) ? 2'($urandom_range(0, 3)) : 2'b00;
    if (r < p_match) return ($urandom_range(0, 3) == 0) ? 2'b11 : rts;
    if (r < p_match + 10) return ~rts;
    return 2'b00;
  endfunction

  task automatic write_word(input logic [15:0] w);
    WordWrite = 1'b1;
    WordIn    = w;
    step();
    WordWrite = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    bit done;
    done      = 1'b0;
    WordWrite = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      DataReceived = rand_ack(RequestToSend, 70);
      step();
      if (mdl_phase == 0 && mdl_fifo.size() == 0) done = 1'b1;
    end
    DataReceived = 2'b00;
    check_eq("drain_done", 32'(done), 32'd1);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    n_checks     = 0;
    n_pass       = 0;
    Reset        = 1'b1;
    WordWrite    = 1'b0;
    WordIn       = 16'h0000;
    DataReceived = 2'b00;
    model_reset();
    step();
    step();
    Reset = 1'b0;
    step();
    check_eq("rst_data",  32'(Data),          32'h0);
    check_eq("rst_rts",   32'(RequestToSend), 32'h0);
    check_eq("rst_ovf",   32'(Overflow),      32'h0);
    check_eq("rst_level", 32'(Level),         32'h0);
    check_eq("rst_busy",  32'(Busy),          32'h0);
    check_eq("rst_ready", 32'(WordReady),     32'h1);

`ifndef TXSEQ_SYNC_EN
    // Single word: latency and the per-byte handshake.
    write_word(16'h1234);
    check_eq("t1_level_n1", 32'(Level), 32'd1);
    step();
    check_eq("t1_data", 32'(Data), 32'h1234);
    check_eq("t1_rts_hi", 32'(RequestToSend), 32'h2);
    DataReceived = 2'b10; step(); DataReceived = 2'b00;
    check_eq("t1_rts_lo", 32'(RequestToSend), 32'h1);
    DataReceived = 2'b01; step(); DataReceived = 2'b00;
    check_eq("t1_rts_done", 32'(RequestToSend), 32'h0);
    check_eq("t1_busy", 32'(Busy), 32'h0);
`endif

    // Short stream (frame/sync ordering when sync is built in).
    for (int i = 1; i <= 4; i++) write_word(16'(i));
    drain(200);

    // A spurious low-byte ack during the high-byte request is ignored.
    write_word(16'hBEEF);
    step();
    DataReceived = 2'b01; step(); DataReceived = 2'b00;
    check_eq("spur_rts", 32'(RequestToSend), 32'h2);
`ifndef TXSEQ_SYNC_EN
    check_eq("spur_data", 32'(Data), 32'hBEEF);
`endif
    drain(200);

    // Fill the FIFO with no acks, then send one write too many.
    WordWrite = 1'b1;
    for (int i = 0; i < 17; i++) begin
      WordIn = 16'($urandom);
      step();
    end
`ifndef TXSEQ_SYNC_EN
    check_eq("fill_ready", 32'(WordReady), 32'h0);
    check_eq("fill_level17", 32'(Level), 32'd16);
    check_eq("fill_ovf_pre", 32'(Overflow), 32'h0);
`endif
    WordIn = 16'($urandom);
    step();
    WordWrite = 1'b0;
    check_eq("fill_ovf", 32'(Overflow), 32'h1);
    check_eq("fill_level", 32'(Level), 32'd16);
    drain(400);

    // Reset while the low byte is requested, with 3 words still queued.
    for (int i = 0; i < 4; i++) write_word(16'($urandom));
    DataReceived = 2'b10; step(); DataReceived = 2'b00;
    check_eq("rm_in_lo", 32'(RequestToSend), 32'h1);
`ifndef TXSEQ_SYNC_EN
    check_eq("rm_level_pre", 32'(Level), 32'd3);
`endif
    Reset = 1'b1; step(); Reset = 1'b0;
    check_eq("rm_rts",   32'(RequestToSend), 32'h0);
    check_eq("rm_level", 32'(Level),         32'h0);
    check_eq("rm_ovf",   32'(Overflow),      32'h0);
    check_eq("rm_busy",  32'(Busy),          32'h0);
`ifdef TXSEQ_SYNC_EN
    check_eq("rm_fcnt", 32'(dut.frame_cnt_q), 32'h0);
`endif

    // A write and a pop in the same IDLE cycle keep the level unchanged.
    for (int i = 0; i < 6; i++) write_word(16'h0100 + 16'(i));
    DataReceived = 2'b10; step();
    DataReceived = 2'b01; step();
    DataReceived = 2'b00;
`ifndef TXSEQ_SYNC_EN
    check_eq("sim_level_pre", 32'(Level), 32'd5);
`endif
    write_word(16'h0106);
`ifndef TXSEQ_SYNC_EN
    check_eq("sim_level", 32'(Level), 32'd5);
    check_eq("sim_rts", 32'(RequestToSend), 32'h2);
`endif
    drain(200);

    // Randomized traffic with random acks and occasional resets.
    for (int c = 0; c < 1500; c++) begin
      Reset        = ($urandom_range(0, 399) == 0);
      WordWrite    = ($urandom_range(0, 99) < 45);
      WordIn       = 16'($urandom);
      DataReceived = rand_ack(RequestToSend, 40);
      step();
    end
    Reset = 1'b0;
    drain(600);
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
